// File: rtl/tick_div_pkg.sv
// Shared encodings and default sizing for the multi-channel tick divider.
package tick_div_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   localparam int unsigned CHANNELS_DEF    = 4;
   localparam int unsigned CNT_W_DEF       = 26;
   localparam int unsigned DEFAULT_DIV_DEF = 500000;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int unsigned chan_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_div_chan.sv
// One divider channel: counter, divisor, periodic/one-shot mode, registered
// tick/sq/busy outputs.
module tick_div_chan
   import tick_div_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   input  logic             cfg_mode_i,
   input  logic             run_i,
   output logic             tick_o,
   output logic             sq_o,
   output logic             busy_o
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, cnt_base;
   mode_e            mode_q, mode_d;
   logic             sq_q, sq_d, armed_q, armed_d, run_d_q, run_d_d;
   logic             tick_q, tick_d, busy_q, busy_d;
   logic             rise, step;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         div_q   <= DIV_RST;
         mode_q  <= MODE_PERIODIC;
         sq_q    <= 1'b0;
         armed_q <= 1'b0;
         run_d_q <= 1'b0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         mode_q  <= mode_d;
         sq_q    <= sq_d;
         armed_q <= armed_d;
         run_d_q <= run_d_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      mode_d   = mode_q;
      sq_d     = sq_q;
      armed_d  = armed_q;
      run_d_d  = run_i;
      tick_d   = 1'b0;
      busy_d   = 1'b0;
      rise     = run_i && !run_d_q;
      step     = 1'b0;
      cnt_base = cnt_q;
      if (cfg_we_i) begin
         // A config write beats a coincident terminal count: no tick.
         div_d   = cfg_div_i;
         mode_d  = mode_e'(cfg_mode_i);
         cnt_d   = '0;
         sq_d    = 1'b0;
         armed_d = 1'b0;
         busy_d  = (mode_e'(cfg_mode_i) == MODE_PERIODIC) && run_i && (cfg_div_i != '0);
      end else if (div_q != '0) begin
         if (mode_q == MODE_PERIODIC) begin
            step = run_i;
         end else begin
            // The triggering edge itself is the first counted cycle.
            step = rise || armed_q;
            if (rise) cnt_base = '0;
            armed_d = step;
         end
         if (step) begin
            if (cnt_base == div_q - CNT_W'(1)) begin
               cnt_d   = '0;
               tick_d  = 1'b1;
               sq_d    = !sq_q;
               armed_d = 1'b0;
            end else begin
               cnt_d = cnt_base + CNT_W'(1);
            end
         end
         busy_d = (mode_q == MODE_PERIODIC) ? run_i : armed_d;
      end else begin
         armed_d = 1'b0;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/tick_divider.sv
// Multi-channel clock-enable generator: config decode, ready/error flags and
// one tick_div_chan per channel.
module tick_divider
   import tick_div_pkg::*;
#(
   parameter  int unsigned CHANNELS    = CHANNELS_DEF,
   parameter  int unsigned CNT_W       = CNT_W_DEF,
   parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
   localparam int unsigned CH_W        = chan_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic                cfg_mode,
   output logic                cfg_err,
   input  logic [CHANNELS-1:0] run,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] sq,
   output logic [CHANNELS-1:0] busy
);

   logic cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
   logic accept, chan_ok;

   assign accept  = cfg_valid && cfg_ready_q;
   assign chan_ok = {1'b0, cfg_chan} < (CH_W + 1)'(CHANNELS);

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   always_comb begin
      cfg_ready_d = 1'b1;
      cfg_err_d   = accept && !chan_ok;
   end

   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      tick_div_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .cfg_we_i   (accept && chan_ok && (cfg_chan == CH_W'(i))),
         .cfg_div_i  (cfg_div),
         .cfg_mode_i (cfg_mode),
         .run_i      (run[i]),
         .tick_o     (tick[i]),
         .sq_o       (sq[i]),
         .busy_o     (busy[i])
      );
   end

endmodule

// File: tb/tick_divider_tb_note.sv


// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider: three channels so that channel index 3 is
// an out-of-range select, small counter width, default divisor 4.
module tb_tick_divider;

   localparam int unsigned NCH  = 3;
   localparam int unsigned CW   = 8;
   localparam int unsigned CHW  = 2;

   typedef struct {
      logic [NCH-1:0] run;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] sq;
      logic [NCH-1:0] busy;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_chan;
   logic [CW-1:0]  cfg_div;
   logic           cfg_mode;
   logic           cfg_err;
   logic [NCH-1:0] run;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;
   logic [NCH-1:0] busy;

   int checks = 0;
   int errors = 0;

   vec_t tbl_per[$];
   vec_t tbl_mix[$];

   always #5 clk = ~clk;

   tick_divider #(
      .CHANNELS    (NCH),
      .CNT_W       (CW),
      .DEFAULT_DIV (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .cfg_err   (cfg_err),
      .run       (run),
      .tick      (tick),
      .sq        (sq),
      .busy      (busy)
   );

   function automatic vec_t mk(input logic [NCH-1:0] r, t, s, b);
      vec_t v;
      v.run  = r;
      v.tick = t;
      v.sq   = s;
      v.busy = b;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply(input logic [NCH-1:0] r, t, s, b, input string tag);
      run = r;
      cyc();
      check({tag, " tick"}, 32'(tick), 32'(t));
      check({tag, " sq"},   32'(sq),   32'(s));
      check({tag, " busy"}, 32'(busy), 32'(b));
   endtask

   task automatic cfg_write(input logic [CHW-1:0] ch, input logic [CW-1:0] d, input logic m,
                            input string tag);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_div   = d;
      cfg_mode  = m;
      cyc();
      cfg_valid = 1'b0;
      check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_chan  = '0;
      cfg_div   = '0;
      cfg_mode  = 1'b0;
      run       = '0;

      // ch0 periodic at the reset divisor of 4
      for (int i = 1; i <= 12; i++) begin
         tbl_per.push_back(mk(3'b001,
                              (i % 4 == 0) ? 3'b001 : 3'b000,
                              (((i / 4) % 2) == 1) ? 3'b001 : 3'b000,
                              3'b001));
      end
      // ch1 D=3 pause/resume, then ch2 D=5 one-shot pulse
      tbl_mix.push_back(mk(3'b010, 3'b000, 3'b001, 3'b010));
      tbl_mix.push_back(mk(3'b010, 3'b000, 3'b001, 3'b010));
      tbl_mix.push_back(mk(3'b010, 3'b010, 3'b011, 3'b010));
      tbl_mix.push_back(mk(3'b010, 3'b000, 3'b011, 3'b010));
      tbl_mix.push_back(mk(3'b010, 3'b000, 3'b011, 3'b010));
      tbl_mix.push_back(mk(3'b000, 3'b000, 3'b011, 3'b000));
      tbl_mix.push_back(mk(3'b000, 3'b000, 3'b011, 3'b000));
      tbl_mix.push_back(mk(3'b010, 3'b010, 3'b001, 3'b010));
      tbl_mix.push_back(mk(3'b000, 3'b000, 3'b001, 3'b000));

      cyc();
      cyc();
      check("rst tick", 32'(tick), 32'd0);
      check("rst sq", 32'(sq), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst cfg_err", 32'(cfg_err), 32'd0);
      check("rst cfg_ready", 32'(cfg_ready), 32'd0);
      reset = 1'b0;
      cyc();
      check("cfg_ready up", 32'(cfg_ready), 32'd1);

      foreach (tbl_per[i])
         apply(tbl_per[i].run, tbl_per[i].tick, tbl_per[i].sq, tbl_per[i].busy,
               $sformatf("per[%0d]", i));
      apply(3'b000, 3'b000, 3'b001, 3'b000, "per stop");

      cfg_write(2'd1, 8'd3, 1'b0, "wr ch1");
      foreach (tbl_mix[i])
         apply(tbl_mix[i].run, tbl_mix[i].tick, tbl_mix[i].sq, tbl_mix[i].busy,
               $sformatf("mix[%0d]", i));

      cfg_write(2'd2, 8'd5, 1'b1, "wr ch2");
      apply(3'b100, 3'b000, 3'b001, 3'b100, "os k");
      for (int i = 1; i <= 3; i++)
         apply(3'b000, 3'b000, 3'b001, 3'b100, $sformatf("os k+%0d", i));
      apply(3'b000, 3'b100, 3'b101, 3'b000, "os fire");
      for (int i = 5; i <= 7; i++)
         apply(3'b000, 3'b000, 3'b101, 3'b000, $sformatf("os k+%0d", i));

      // ch0 D=4: write D=2 on the edge that would be terminal
      for (int i = 1; i <= 3; i++)
         apply(3'b001, 3'b000, 3'b101, 3'b001, $sformatf("term e%0d", i));
      cfg_valid = 1'b1;
      cfg_chan  = 2'd0;
      cfg_div   = 8'd2;
      cfg_mode  = 1'b0;
      apply(3'b001, 3'b000, 3'b100, 3'b001, "term cfg");
      cfg_valid = 1'b0;
      apply(3'b001, 3'b000, 3'b100, 3'b001, "term e5");
      apply(3'b001, 3'b001, 3'b101, 3'b001, "term e6");
      apply(3'b000, 3'b000, 3'b101, 3'b000, "term stop");

      cfg_valid = 1'b1;
      cfg_chan  = 2'd3;
      cfg_div   = 8'd1;
      cfg_mode  = 1'b0;
      apply(3'b000, 3'b000, 3'b101, 3'b000, "bad ch");
      check("bad ch cfg_err", 32'(cfg_err), 32'd1);
      cfg_valid = 1'b0;
      apply(3'b000, 3'b000, 3'b101, 3'b000, "bad ch+1");
      check("bad ch+1 cfg_err", 32'(cfg_err), 32'd0);
      apply(3'b010, 3'b000, 3'b101, 3'b010, "ch1 kept e1");
      apply(3'b010, 3'b000, 3'b101, 3'b010, "ch1 kept e2");
      apply(3'b010, 3'b010, 3'b111, 3'b010, "ch1 kept e3");
      apply(3'b000, 3'b000, 3'b111, 3'b000, "ch1 stop");

      cfg_write(2'd1, 8'd0, 1'b0, "wr d0");
      for (int i = 0; i < 3; i++)
         apply(3'b010, 3'b000, 3'b101, 3'b000, $sformatf("d0 e%0d", i));
      apply(3'b000, 3'b000, 3'b101, 3'b000, "d0 stop");

      cfg_write(2'd0, 8'd1, 1'b0, "wr d1");
      apply(3'b001, 3'b001, 3'b101, 3'b001, "d1 e1");
      apply(3'b001, 3'b001, 3'b100, 3'b001, "d1 e2");
      reset = 1'b1;
      apply(3'b001, 3'b000, 3'b000, 3'b000, "mid rst");
      check("mid rst cfg_ready", 32'(cfg_ready), 32'd0);
      reset = 1'b0;
      apply(3'b001, 3'b000, 3'b000, 3'b001, "post rst e1");
      check("post rst cfg_ready", 32'(cfg_ready), 32'd1);
      apply(3'b001, 3'b000, 3'b000, 3'b001, "post rst e2");
      apply(3'b001, 3'b000, 3'b000, 3'b001, "post rst e3");
      apply(3'b001, 3'b001, 3'b001, 3'b001, "post rst e4");
      apply(3'b000, 3'b000, 3'b001, 3'b000, "post rst stop");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
